// File: rtl/mod_sbox_lanes.sv
// mod_sbox_lanes
//   Pipelined AES byte-substitution unit shared by the round datapath
//   (SubBytes) and the key schedule (SubWord). Every lane of a beat is looked
//   up independently in the forward S-box, or in the inverse S-box when the
//   beat asks for it and INV_EN is set. Valid/ready handshake on both sides,
//   with no skid buffer.
//
// Parameters
//   LANES  : byte lanes per beat (1..16), data width is 8*LANES
//   PIPE   : register stages from acceptance to output (1 or 2)
//   INV_EN : 1 = inverse table present, 0 = forward table only
//
// Ports
//   clk        in   system clock, rising edge
//   resetn     in   asynchronous active-low reset
//   in_valid   in   input beat valid
//   in_ready   out  beat accepted this cycle if in_valid (comb from out_ready)
//   in_inv     in   beat mode: 0 = forward, 1 = inverse
//   in_data    in   input bytes, lane k at [8k+7:8k]
//   out_valid  out  output beat valid
//   out_ready  in   downstream takes the output beat
//   out_data   out  substituted bytes, lane-aligned with in_data
//   out_inv    out  mode bit carried with the beat
//   in_flight  out  beats currently held in the pipeline
//   err_mode   out  sticky: inverse requested while INV_EN = 0
module mod_sbox_lanes #(
  parameter int LANES  = 4,
  parameter int PIPE   = 1,
  parameter bit INV_EN = 1'b1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_inv,
  input  logic [8*LANES-1:0]         in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*LANES-1:0]         out_data,
  output logic                       out_inv,
  output logic [$clog2(PIPE+1)-1:0]  in_flight,
  output logic                       err_mode
);

  localparam int DW = 8 * LANES;
  localparam int CW = $clog2(PIPE + 1);

  // Byte x of each table sits at bits [8*(255-x) +: 8]; rows are 16 entries.
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] SBOX_INV = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] sub_fwd(input logic [7:0] b);
    return SBOX_FWD[8*(255-int'(b)) +: 8];
  endfunction

  function automatic logic [7:0] sub_inv(input logic [7:0] b);
    return SBOX_INV[8*(255-int'(b)) +: 8];
  endfunction

  // Stage registers: index 0 is the lookup stage, PIPE-1 drives the outputs.
  logic [PIPE-1:0]         vld_q, vld_d;
  logic [PIPE-1:0]         inv_q, inv_d;
  logic [PIPE-1:0][DW-1:0] dat_q, dat_d;
  logic [CW-1:0]           flight_q, flight_d;
  logic                    err_q, err_d;

  logic [PIPE-1:0] adv;
  logic [DW-1:0]   lut_data;
  logic            use_inv;
  logic            in_xfer;
  logic            out_xfer;

  // With INV_EN = 0 this is constant 0, so the inverse table folds away.
  assign use_inv = INV_EN && in_inv;

  always_comb begin
    lut_data = '0;
    for (int k = 0; k < LANES; k++) begin
      if (use_inv) lut_data[8*k +: 8] = sub_inv(in_data[8*k +: 8]);
      else         lut_data[8*k +: 8] = sub_fwd(in_data[8*k +: 8]);
    end
  end

  // Stall chain: a stage may load when it is empty or its successor moves on.
  // Walked from the output end so in_ready sees out_ready combinationally.
  always_comb begin
    logic chain;
    adv            = '0;
    chain          = !vld_q[PIPE-1] || out_ready;
    adv[PIPE-1]    = chain;
    for (int i = PIPE - 2; i >= 0; i--) begin
      chain  = !vld_q[i] || chain;
      adv[i] = chain;
    end
  end

  assign in_ready = adv[0];
  assign in_xfer  = in_valid && adv[0];
  assign out_xfer = vld_q[PIPE-1] && out_ready;

  always_comb begin
    vld_d = vld_q;
    inv_d = inv_q;
    dat_d = dat_q;

    if (adv[0]) begin
      vld_d[0] = in_valid;
      if (in_valid) begin
        inv_d[0] = in_inv;
        dat_d[0] = lut_data;
      end
    end

    for (int i = 1; i < PIPE; i++) begin
      if (adv[i]) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) begin
          inv_d[i] = inv_q[i-1];
          dat_d[i] = dat_q[i-1];
        end
      end
    end
  end

  always_comb begin
    flight_d = flight_q;
    case ({in_xfer, out_xfer})
      2'b10:   flight_d = flight_q + CW'(1);
      2'b01:   flight_d = flight_q - CW'(1);
      default: flight_d = flight_q;
    endcase
  end

  // An inverse request without an inverse table is served forward and flagged.
  assign err_d = err_q || (!INV_EN && in_xfer && in_inv);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_q    <= '0;
      inv_q    <= '0;
      dat_q    <= '0;
      flight_q <= '0;
      err_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      inv_q    <= inv_d;
      dat_q    <= dat_d;
      flight_q <= flight_d;
      err_q    <= err_d;
    end
  end

  assign out_valid = vld_q[PIPE-1];
  assign out_data  = dat_q[PIPE-1];
  assign out_inv   = inv_q[PIPE-1];
  assign in_flight = flight_q;
  assign err_mode  = err_q;

endmodule

// File: tb/tb_mod_sbox_lanes.sv
// Bench for mod_sbox_lanes. Three instances share clock and reset:
//   a : PIPE=1, INV_EN=1  (table vectors, alternating modes, 256-value sweeps)
//   b : PIPE=2, INV_EN=1  (backpressure ordering, mid-stream reset)
//   c : PIPE=1, INV_EN=0  (unsupported mode, sticky err_mode)
module tb_mod_sbox_lanes;

  logic clk;
  logic resetn;

  logic        a_in_valid, a_in_ready, a_in_inv, a_out_valid, a_out_ready, a_out_inv, a_err_mode;
  logic [31:0] a_in_data, a_out_data;
  logic [0:0]  a_in_flight;

  logic        b_in_valid, b_in_ready, b_in_inv, b_out_valid, b_out_ready, b_out_inv, b_err_mode;
  logic [31:0] b_in_data, b_out_data;
  logic [1:0]  b_in_flight;

  logic        c_in_valid, c_in_ready, c_in_inv, c_out_valid, c_out_ready, c_out_inv, c_err_mode;
  logic [31:0] c_in_data, c_out_data;
  logic [0:0]  c_in_flight;

  int errors = 0;
  int checks = 0;

  mod_sbox_lanes #(.LANES(4), .PIPE(1), .INV_EN(1'b1)) dut_a (
    .clk(clk), .resetn(resetn),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_inv(a_in_inv), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_inv(a_out_inv),
    .in_flight(a_in_flight), .err_mode(a_err_mode)
  );

  mod_sbox_lanes #(.LANES(4), .PIPE(2), .INV_EN(1'b1)) dut_b (
    .clk(clk), .resetn(resetn),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_inv(b_in_inv), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_inv(b_out_inv),
    .in_flight(b_in_flight), .err_mode(b_err_mode)
  );

  mod_sbox_lanes #(.LANES(4), .PIPE(1), .INV_EN(1'b0)) dut_c (
    .clk(clk), .resetn(resetn),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_inv(c_in_inv), .in_data(c_in_data),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data), .out_inv(c_out_inv),
    .in_flight(c_in_flight), .err_mode(c_err_mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Upstream must hold a beat until it is taken.
  a_hold: assert property (@(posedge clk) disable iff (!resetn) (a_in_valid && !a_in_ready) |=> a_in_valid)
    else $error("protocol: a_in_valid dropped without transfer");
  b_hold: assert property (@(posedge clk) disable iff (!resetn) (b_in_valid && !b_in_ready) |=> b_in_valid)
    else $error("protocol: b_in_valid dropped without transfer");

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated beat through dut a; returns out_data one cycle later.
  task automatic a_xfer(input logic inv, input logic [31:0] din, output logic [31:0] dout);
    @(negedge clk);
    a_in_valid = 1'b1;
    a_in_inv   = inv;
    a_in_data  = din;
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    chk("sweep_valid", 32'(a_out_valid), 32'd1);
    dout = a_out_data;
  endtask

  typedef struct {
    logic        inv;
    logic [31:0] din;
    logic [31:0] dout;
  } vec_t;

  vec_t vecs[12];

  logic [32:0] expq[$];
  logic [32:0] exp_beat;
  logic [31:0] b_din[4];
  logic        b_binv[4];
  logic [31:0] b_dexp[4];
  logic [7:0]  c_in_b[10];
  logic [7:0]  c_out_b[10];
  logic [31:0] y, z;

  initial begin
    vecs[0]  = '{1'b0, 32'h0053ff01, 32'h63ed167c};
    vecs[1]  = '{1'b1, 32'h63ed167c, 32'h0053ff01};
    vecs[2]  = '{1'b0, 32'h00000000, 32'h63636363};
    vecs[3]  = '{1'b1, 32'h63636363, 32'h00000000};
    vecs[4]  = '{1'b0, 32'h53535353, 32'hedededed};
    vecs[5]  = '{1'b1, 32'h16161616, 32'hffffffff};
    vecs[6]  = '{1'b0, 32'h10203040, 32'hcab70409};
    vecs[7]  = '{1'b1, 32'hcab70409, 32'h10203040};
    vecs[8]  = '{1'b0, 32'h01234567, 32'h7c266e85};
    vecs[9]  = '{1'b1, 32'h7c266e85, 32'h01234567};
    vecs[10] = '{1'b0, 32'hffffffff, 32'h16161616};
    vecs[11] = '{1'b1, 32'hedededed, 32'h53535353};

    b_din[0] = 32'h00000000; b_binv[0] = 1'b0; b_dexp[0] = 32'h63636363;
    b_din[1] = 32'h63ed167c; b_binv[1] = 1'b1; b_dexp[1] = 32'h0053ff01;
    b_din[2] = 32'h0053ff01; b_binv[2] = 1'b0; b_dexp[2] = 32'h63ed167c;
    b_din[3] = 32'h16161616; b_binv[3] = 1'b1; b_dexp[3] = 32'hffffffff;

    c_in_b  = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    c_out_b = '{8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01};

    resetn = 1'b0;
    a_in_valid = 1'b0; a_in_inv = 1'b0; a_in_data = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_inv = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_inv = 1'b0; c_in_data = '0; c_out_ready = 1'b0;

    // ---------------- reset state
    #1;
    chk("rst_a_valid",  32'(a_out_valid), 32'd0);
    chk("rst_a_data",   a_out_data, 32'd0);
    chk("rst_a_inv",    32'(a_out_inv), 32'd0);
    chk("rst_a_flight", 32'(a_in_flight), 32'd0);
    chk("rst_b_valid",  32'(b_out_valid), 32'd0);
    chk("rst_b_flight", 32'(b_in_flight), 32'd0);
    chk("rst_c_err",    32'(c_err_mode), 32'd0);
    chk("rst_a_ready",  32'(a_in_ready), 32'd1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    a_out_ready = 1'b1;
    c_out_ready = 1'b1;

    // ---------------- table vectors, back to back with alternating modes
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      a_in_valid = 1'b1;
      a_in_inv   = vecs[i].inv;
      a_in_data  = vecs[i].din;
      #1;
      chk("tbl_in_ready", 32'(a_in_ready), 32'd1);
      if (i > 0) begin
        chk("tbl_out_valid", 32'(a_out_valid), 32'd1);
        chk("tbl_out_data",  a_out_data, vecs[i-1].dout);
        chk("tbl_out_inv",   32'(a_out_inv), 32'(vecs[i-1].inv));
        chk("tbl_flight",    32'(a_in_flight), 32'd1);
      end
    end
    @(negedge clk);
    a_in_valid = 1'b0;
    #1;
    chk("tbl_last_valid", 32'(a_out_valid), 32'd1);
    chk("tbl_last_data",  a_out_data, vecs[11].dout);
    @(negedge clk);
    #1;
    chk("tbl_idle_valid",  32'(a_out_valid), 32'd0);
    chk("tbl_idle_flight", 32'(a_in_flight), 32'd0);

    // ---------------- lane-0 sweep, both starting modes, round trip
    for (int x = 0; x < 256; x++) begin
      for (int m = 0; m < 2; m++) begin
        a_xfer(m[0], {24'h0, 8'(x)}, y);
        chk("sweep_upper", {8'h0, y[31:8]}, (m == 0) ? 32'h00636363 : 32'h00525252);
        a_xfer(!m[0], {24'h0, y[7:0]}, z);
        chk("sweep_roundtrip", {24'h0, z[7:0]}, 32'(x));
      end
    end

    // ---------------- unsupported mode on dut c
    @(negedge clk);
    c_in_valid = 1'b1; c_in_inv = 1'b1; c_in_data = 32'h00000000;
    #1;
    chk("err_before_edge", 32'(c_err_mode), 32'd0);
    @(negedge clk);
    c_in_valid = 1'b0; c_in_inv = 1'b0;
    #1;
    chk("err_out_data", c_out_data, 32'h63636363);
    chk("err_out_inv",  32'(c_out_inv), 32'd1);
    chk("err_set",      32'(c_err_mode), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      c_in_valid = 1'b1; c_in_inv = 1'b0; c_in_data = {4{c_in_b[i]}};
      #1;
      if (i > 0) begin
        chk("err_fwd_data", c_out_data, {4{c_out_b[i-1]}});
        chk("err_sticky",   32'(c_err_mode), 32'd1);
      end
    end
    @(negedge clk);
    c_in_valid = 1'b0;
    #1;
    chk("err_fwd_last", c_out_data, {4{c_out_b[9]}});
    chk("err_fwd_inv",  32'(c_out_inv), 32'd0);
    chk("err_sticky_end", 32'(c_err_mode), 32'd1);

    // ---------------- backpressure on dut b (PIPE=2)
    begin
      int idx, outs, cyc;
      idx = 0; outs = 0; cyc = 0;
      @(negedge clk);
      while (outs < 4 && cyc < 30) begin
        b_out_ready = (cyc >= 5);
        b_in_valid  = (idx < 4);
        b_in_inv    = (idx < 4) ? b_binv[idx] : 1'b0;
        b_in_data   = (idx < 4) ? b_din[idx] : 32'h0;
        #1;
        if (cyc == 2) begin
          chk("bp_ready_low",  32'(b_in_ready), 32'd0);
          chk("bp_flight_full", 32'(b_in_flight), 32'd2);
          chk("bp_head_data",  b_out_data, b_dexp[0]);
        end
        if (cyc == 4) begin
          chk("bp_stable_data", b_out_data, b_dexp[0]);
          chk("bp_stable_inv",  32'(b_out_inv), 32'd0);
        end
        if (cyc == 5 || cyc == 6) begin
          chk("bp_full_ready", 32'(b_in_ready), 32'd1);
          chk("bp_full_flight", 32'(b_in_flight), 32'd2);
        end
        if (b_out_valid && b_out_ready) begin
          if (expq.size() == 0) begin
            chk("bp_extra_beat", b_out_data, 32'hxxxxxxxx);
          end else begin
            exp_beat = expq.pop_front();
            chk("bp_order_data", b_out_data, exp_beat[31:0]);
            chk("bp_order_inv",  32'(b_out_inv), 32'(exp_beat[32]));
          end
          outs++;
        end
        if (b_in_valid && b_in_ready) begin
          expq.push_back({b_binv[idx], b_dexp[idx]});
          idx++;
        end
        @(negedge clk);
        cyc++;
      end
      chk("bp_drain_cycle", 32'(cyc), 32'd9);
      b_in_valid = 1'b0;
      #1;
      chk("bp_flight_empty", 32'(b_in_flight), 32'd0);
      chk("bp_no_dup", 32'(b_out_valid), 32'd0);
    end

    // ---------------- reset mid-stream, dut b full
    @(negedge clk);
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_data = 32'h01010101;
    @(negedge clk);
    b_in_data = 32'h53535353;
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    chk("mr_full_flight", 32'(b_in_flight), 32'd2);
    chk("mr_full_valid",  32'(b_out_valid), 32'd1);
    chk("mr_full_data",   b_out_data, 32'h7c7c7c7c);
    chk("mr_err_pre",     32'(c_err_mode), 32'd1);
    #1;
    resetn = 1'b0;
    #1;
    chk("mr_async_valid",  32'(b_out_valid), 32'd0);
    chk("mr_async_data",   b_out_data, 32'd0);
    chk("mr_async_flight", 32'(b_in_flight), 32'd0);
    chk("mr_async_err",    32'(c_err_mode), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("mr_no_stale", 32'(b_out_valid), 32'd0);
    end
    @(negedge clk);
    b_in_valid = 1'b1; b_in_inv = 1'b0; b_in_data = 32'hffffffff;
    @(negedge clk);
    b_in_valid = 1'b0;
    #1;
    chk("mr_lat_early",  32'(b_out_valid), 32'd0);
    chk("mr_lat_flight", 32'(b_in_flight), 32'd1);
    @(negedge clk);
    #1;
    chk("mr_lat_valid", 32'(b_out_valid), 32'd1);
    chk("mr_lat_data",  b_out_data, 32'h16161616);
    @(negedge clk);
    #1;
    chk("mr_after_valid", 32'(b_out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
